// File: rtl/dac7554_pkg.sv
// rtl/dac7554_pkg.sv - frame geometry, command codes and receiver states for the DAC7554 link
package dac7554_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int NUM_CH     = 4;
  localparam int CNT_BITS   = 5;

  typedef enum logic [1:0] {
    CMD_LOAD         = 2'b00,
    CMD_LOAD_UPD     = 2'b01,
    CMD_LOAD_UPD_ALL = 2'b10,
    CMD_UPD_ALL      = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CLOSE = 2'd2
  } state_e;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
    return NUM_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - N-flop synchronizer with rise/fall detect against one extra register
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Resetting to 0 means a line held low through reset never yields a falling edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/dac_spi_rx.sv
// rtl/dac_spi_rx.sv - DAC7554-style SPI frame receiver; DACRX_FRAME_CHECK_EN adds frame_err/err_cnt
module dac_spi_rx
  import dac7554_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 sync,
  input  logic                 sclk,
  input  logic                 sdi,
  output logic                 frame_vld,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic [DATA_BITS-1:0] dac_a,
  output logic [DATA_BITS-1:0] dac_b,
  output logic [DATA_BITS-1:0] dac_c,
  output logic [DATA_BITS-1:0] dac_d,
  output logic [NUM_CH-1:0]    upd_stb,
  output logic                 frame_err
`ifdef DACRX_FRAME_CHECK_EN
  ,
  output logic [15:0]          err_cnt
`endif
);

  logic sync_lvl, sync_rise, sync_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] sdi_q;
  logic sdi_s;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
    .clk_in(clk_in), .rst_n(rst_n), .d_i(sync),
    .q_o(sync_lvl), .rise_o(sync_rise), .fall_o(sync_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_edge (
    .clk_in(clk_in), .rst_n(rst_n), .d_i(sclk),
    .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // Same depth as sclk so the sampled bit lines up with the detected falling edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) sdi_q <= '0;
    else        sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
  end
  assign sdi_s        = sdi_q[SYNC_STAGES-1];
  assign unused_edges = ^{sync_lvl, sclk_lvl, sclk_rise};

  state_e state_q, state_d;
  logic   clr, shift_en, close, accept;

  logic [FRAME_BITS-1:0]             shift_q, shift_d;
  logic [CNT_BITS-1:0]               cnt_q, cnt_d;
  logic [NUM_CH-1:0][DATA_BITS-1:0]  in_q, in_d, out_q, out_d;
  logic [FRAME_BITS-1:0]             data_q, data_d;
  logic [NUM_CH-1:0]                 upd_q, upd_d;
  logic                              vld_q;
  cmd_e                              cmd;
  logic [1:0]                        addr;
  logic [DATA_BITS-1:0]              dat;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sync_fall) state_d = SHIFT;
      SHIFT:   if (sync_rise) state_d = CLOSE;
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr      = 1'b0;
    shift_en = 1'b0;
    close    = 1'b0;
    unique case (state_q)
      IDLE:    clr      = sync_fall;
      SHIFT:   shift_en = sclk_fall;
      CLOSE:   close    = 1'b1;
      default: ;
    endcase
  end

  assign accept = close && (cnt_q == CNT_BITS'(FRAME_BITS));
  assign cmd    = cmd_e'(shift_q[15:14]);
  assign addr   = shift_q[13:12];
  assign dat    = shift_q[DATA_BITS-1:0];

  // A bit shifted on the same cycle as the sync rise still lands before CLOSE.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    out_d   = out_q;
    data_d  = data_q;
    upd_d   = '0;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = {shift_q[FRAME_BITS-2:0], sdi_s};
      if (cnt_q != '1) cnt_d = cnt_q + CNT_BITS'(1);
    end
    if (accept) begin
      data_d = shift_q;
      if (cmd != CMD_UPD_ALL) in_d[addr] = dat;
      case (cmd)
        CMD_LOAD_UPD: begin
          out_d[addr] = dat;
          upd_d       = ch_onehot(addr);
        end
        CMD_LOAD_UPD_ALL, CMD_UPD_ALL: begin
          out_d = in_d;
          upd_d = '1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
      data_q  <= '0;
      upd_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      out_q   <= out_d;
      data_q  <= data_d;
      upd_q   <= upd_d;
      vld_q   <= accept;
    end
  end

  assign frame_vld  = vld_q;
  assign frame_data = data_q;
  assign upd_stb    = upd_q;
  assign dac_a      = out_q[0];
  assign dac_b      = out_q[1];
  assign dac_c      = out_q[2];
  assign dac_d      = out_q[3];

`ifdef DACRX_FRAME_CHECK_EN
  logic        err_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= close && !accept;
      if (close && !accept && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign frame_err = err_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule
